exe_stage: RTL
==============

# exe_stage

Execute stage of the five-stage scalar pipeline, between the decode stage and the memory-access stage. It latches the decode bundle, drives the shared combinational ALU and the external pipelined multiplier, and runs an internal 32-cycle iterative divider that stalls the stage while busy. It issues load/store requests to the data SRAM, packs the memory-stage bundle, and publishes a forwarding/hazard record for decode.

## Interface
- No parameters; bundle widths are fixed at `ID_TO_EX_WIDTH`=161 and `EX_TO_MEM_WIDTH`=109.
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- ex_allowin  out  1  stage can accept a new bundle
- id_to_ex_valid  in  1  decode bundle valid
- id_to_ex_wire  in  161  bundle, MSB first: rf_we(1), rf_waddr(5), pc(32), alu_op(12), alu_src1(32), alu_src2(32), rkd_value(32), mem_op(8: ld_b, ld_bu, ld_h, ld_hu, ld_w, st_b, st_h, st_w), mul_op(3: mul_w, mulh_w, mulh_wu), div_op(4: div_w, mod_w, div_wu, mod_wu)
- mem_allowin  in  1  memory stage can accept
- ex_to_mem_valid  out  1  output bundle valid
- ex_to_mem_wire  out  109  MSB first: rf_we, rf_waddr, pc, alu_result, ld_b, ld_bu, ld_h, ld_hu, ld_w, res_from_mul, res_from_div, div_result
- alu_op  out  12; alu_src1, alu_src2  out  32 each  ALU operands (registered fields)
- alu_result  in  32  combinational ALU result
- mul_op  out  3; mul_src1, mul_src2  out  32 each  multiplier operands; mul_op gated by ex_valid
- data_sram_en  out  1; data_sram_we  out  4; data_sram_addr  out  32; data_sram_wdata  out  32
- ex_rf_zip  out  39  {rf_we & ex_valid, res_from_mem, rf_waddr, alu_result}

## Operation
- Pipeline control: ex_ready_go = ~|div_op | div_done. ex_allowin = ~ex_valid | (ex_ready_go & mem_allowin). ex_to_mem_valid = ex_valid & ex_ready_go. ex_valid loads id_to_ex_valid whenever ex_allowin is high. The bundle register loads when id_to_ex_valid & ex_allowin.
- Memory request:
  - data_sram_en = ex_valid & ex_ready_go & mem_allowin & |mem_op. It is asserted for exactly one cycle per instruction.
  - data_sram_addr = alu_result.
  - st_b: we = 4'b0001 << addr[1:0], wdata = rkd_value[7:0] replicated ×4.
  - st_h: we = addr[1] ? 4'b1100 : 4'b0011, wdata = rkd_value[15:0] replicated ×2.
  - st_w: we = 4'b1111, wdata = rkd_value.
  - Loads: we = 0.
- res_from_mem = OR of the five load flags. res_from_mul = |mul_op. res_from_div = |div_op.
- Divider FSM: IDLE → CALC → DONE → IDLE.
  - IDLE→CALC: ex_valid & |div_op. On this transition, latch |src1|, |src2| (signed ops) or the raw operands (unsigned ops), the quotient sign (src1[31]^src2[31]) and the remainder sign (src1[31]). Clear the 6-bit counter.
  - CALC: one restoring step per cycle on a 33-bit partial remainder. The counter increments from 0 to 31; leave for DONE after the step where the counter equals 31.
  - DONE: div_done = 1. Apply sign fix-ups. div_result = quotient for div_w/div_wu, remainder for mod_w/mod_wu. Stay in DONE until mem_allowin, then go to IDLE the same cycle the bundle is accepted.
  - Divisor zero: quotient = 0xFFFFFFFF and remainder = dividend (raw src1), for all four ops, with no sign fix-up.
  - -2^31 / -1: quotient = 0x80000000, remainder = 0 (natural wrap).
- Reset (synchronous, any state, including mid-division) sets ex_valid = 0, FSM = IDLE, counter = 0, and discards any partial result.

## Timing
- Outputs after reset: ex_valid = 0, ex_to_mem_valid = 0, data_sram_en = 0, data_sram_we = 0, ex_rf_zip[38] = 0, mul_op = 0, ex_allowin = 1. The data bundle register is not reset.
- Non-divide instruction: one cycle in the stage when mem_allowin = 1.
- Divide instruction:
  - Cycle 0: instruction enters.
  - Cycle 0 → 1: IDLE→CALC.
  - Cycles 1–32: CALC.
  - Cycle 33: DONE, ex_to_mem_valid = 1.
  - Total occupancy is 34 cycles when mem_allowin stays high.
  - ex_allowin stays 0 throughout the divide.
- Back-to-back divides: the second divide starts IDLE→CALC on the cycle after the first is accepted.
- mem_allowin low while in DONE: hold div_result, ex_to_mem_valid and the bundle stable. Assert no extra data_sram_en.
- A memory request and the hand-off to the memory stage occur in the same cycle.

## Test plan
- ALU op followed by a store: alu_result = 0x1002, st_h, rkd = 0xABCD1234 → we = 4'b1100, wdata = 0x12341234, en high exactly one cycle.
- div_w 0xFFFFFFF9 / 0x00000002 → div_result = 0xFFFFFFFD; mod_w on the same operands → 0xFFFFFFFF. Each result appears at cycle 33 and ex_allowin = 0 throughout.
- div_wu 0x00000007 / 0 → 0xFFFFFFFF; mod_wu → 0x00000007. div_w 0x80000000 / 0xFFFFFFFF → 0x80000000.
- mem_allowin held low 5 cycles in DONE → result stable and no data_sram_en. When mem_allowin is released, the next instruction enters on the following cycle.
- resetn low at CALC counter = 10 → next cycle ex_valid = 0 and FSM = IDLE. A new divide then completes with a correct result.
- Load ld_w to r5 → ex_rf_zip = {1, 1, 5'd5, addr}. Bubble (id_to_ex_valid = 0) → ex_rf_zip[38] = 0.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage: latches the decode bundle, drives the ALU/multiplier operands, runs a
// 32-step restoring divider, issues data SRAM requests and forwards a hazard record.
// Latency: 1 cycle for non-divide ops; 34 cycles for divide ops (enter, 32 steps, done).
// Backpressure: holds the bundle and result while mem_allowin is low; ex_allowin is 0 while busy.
// Ports: clk/resetn (sync, active-low); id_to_ex_* in from decode, ex_allowin back to decode;
//        ex_to_mem_* out to memory stage, mem_allowin back; alu_*/mul_* operand and result
//        links to the shared ALU and external multiplier; data_sram_* request; ex_rf_zip forward.
module exe_stage (
  input  logic         clk,
  input  logic         resetn,
  output logic         ex_allowin,
  input  logic         id_to_ex_valid,
  input  logic [160:0] id_to_ex_wire,
  input  logic         mem_allowin,
  output logic         ex_to_mem_valid,
  output logic [108:0] ex_to_mem_wire,
  output logic [11:0]  alu_op,
  output logic [31:0]  alu_src1,
  output logic [31:0]  alu_src2,
  input  logic [31:0]  alu_result,
  output logic [2:0]   mul_op,
  output logic [31:0]  mul_src1,
  output logic [31:0]  mul_src2,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_we,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata,
  output logic [38:0]  ex_rf_zip
);

  localparam int ID_TO_EX_WIDTH  = 161;
  localparam int EX_TO_MEM_WIDTH = 109;

  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_t;

  logic                      ex_valid;
  logic                      ex_ready_go;
  logic [ID_TO_EX_WIDTH-1:0] id_r;

  // Decoded fields of the latched bundle
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] pc;
  logic [31:0] rkd_value;
  logic        ld_b, ld_bu, ld_h, ld_hu, ld_w, st_b, st_h, st_w;
  logic [2:0]  mul_op_r;
  logic        div_w, mod_w, div_wu, mod_wu;

  assign {rf_we, rf_waddr, pc, alu_op, alu_src1, alu_src2, rkd_value,
          ld_b, ld_bu, ld_h, ld_hu, ld_w, st_b, st_h, st_w,
          mul_op_r, div_w, mod_w, div_wu, mod_wu} = id_r;

  logic div_any, div_signed, res_from_mem, mem_any;
  assign div_any      = div_w | mod_w | div_wu | mod_wu;
  assign div_signed   = div_w | mod_w;
  assign res_from_mem = ld_b | ld_bu | ld_h | ld_hu | ld_w;
  assign mem_any      = res_from_mem | st_b | st_h | st_w;

  // ---------------------------------------------------------------------------
  // Pipeline handshake
  // ---------------------------------------------------------------------------
  logic div_done;

  assign ex_ready_go     = ~div_any | div_done;
  assign ex_allowin      = ~ex_valid | (ex_ready_go & mem_allowin);
  assign ex_to_mem_valid = ex_valid & ex_ready_go;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ex_valid <= 1'b0;
    end else if (ex_allowin) begin
      ex_valid <= id_to_ex_valid;
    end
  end

  // Data bundle carries no reset; ex_valid qualifies it.
  always_ff @(posedge clk) begin
    if (id_to_ex_valid && ex_allowin) begin
      id_r <= id_to_ex_wire;
    end
  end

  // ---------------------------------------------------------------------------
  // Iterative divider
  // ---------------------------------------------------------------------------
  div_state_t  div_state, div_state_nxt;
  logic        div_start;
  logic [5:0]  div_cnt;
  logic [31:0] div_rem;   // partial remainder
  logic [31:0] div_quo;   // dividend bits shift out of the top, quotient bits shift in at the bottom
  logic [31:0] div_dvs;
  logic        q_neg, r_neg;

  logic [31:0] src1_abs, src2_abs;
  assign src1_abs = alu_src1[31] ? (32'd0 - alu_src1) : alu_src1;
  assign src2_abs = alu_src2[31] ? (32'd0 - alu_src2) : alu_src2;

  // The 33-bit partial remainder of a step is {div_rem[31], step_lo}. Because the true
  // difference always fits in 32 bits, a modulo-2^32 subtract is exact whenever the
  // carry bit or the compare says the divisor fits.
  logic [31:0] step_lo, step_diff;
  logic        step_ge;
  assign step_lo   = {div_rem[30:0], div_quo[31]};
  assign step_ge   = div_rem[31] | (step_lo >= div_dvs);
  assign step_diff = step_lo - div_dvs;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_state <= DIV_IDLE;
    end else begin
      div_state <= div_state_nxt;
    end
  end

  always_comb begin
    div_state_nxt = div_state;
    div_start     = 1'b0;
    unique case (div_state)
      DIV_IDLE: begin
        if (ex_valid && div_any) begin
          div_state_nxt = DIV_CALC;
          div_start     = 1'b1;
        end
      end
      DIV_CALC: begin
        if (div_cnt == 6'd31) begin
          div_state_nxt = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (mem_allowin) begin
          div_state_nxt = DIV_IDLE;
        end
      end
      default: div_state_nxt = DIV_IDLE;
    endcase
  end

  assign div_done = (div_state == DIV_DONE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_cnt <= 6'd0;
      div_rem <= 32'd0;
      div_quo <= 32'd0;
      div_dvs <= 32'd0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
    end else if (div_start) begin
      div_cnt <= 6'd0;
      div_rem <= 32'd0;
      if (alu_src2 == 32'd0) begin
        // A zero divisor run on the raw dividend without sign fix-up naturally yields
        // an all-ones quotient and the dividend as remainder.
        div_quo <= alu_src1;
        div_dvs <= 32'd0;
        q_neg   <= 1'b0;
        r_neg   <= 1'b0;
      end else if (div_signed) begin
        div_quo <= src1_abs;
        div_dvs <= src2_abs;
        q_neg   <= alu_src1[31] ^ alu_src2[31];
        r_neg   <= alu_src1[31];
      end else begin
        div_quo <= alu_src1;
        div_dvs <= alu_src2;
        q_neg   <= 1'b0;
        r_neg   <= 1'b0;
      end
    end else if (div_state == DIV_CALC) begin
      div_cnt <= div_cnt + 6'd1;
      div_rem <= step_ge ? step_diff : step_lo;
      div_quo <= {div_quo[30:0], step_ge};
    end
  end

  logic [31:0] quo_fix, rem_fix, div_result;
  assign quo_fix    = q_neg ? (32'd0 - div_quo) : div_quo;
  assign rem_fix    = r_neg ? (32'd0 - div_rem) : div_rem;
  assign div_result = (div_w | div_wu) ? quo_fix : rem_fix;

  // ---------------------------------------------------------------------------
  // Multiplier, memory request, outputs
  // ---------------------------------------------------------------------------
  assign mul_op   = ex_valid ? mul_op_r : 3'b000;
  assign mul_src1 = alu_src1;
  assign mul_src2 = alu_src2;

  // Request fires only in the hand-off cycle, so a stalled instruction issues once.
  assign data_sram_en   = ex_valid & ex_ready_go & mem_allowin & mem_any;
  assign data_sram_addr = alu_result;

  always_comb begin
    data_sram_we    = 4'b0000;
    data_sram_wdata = rkd_value;
    if (ex_valid) begin
      if (st_b) begin
        data_sram_we    = 4'b0001 << alu_result[1:0];
        data_sram_wdata = {4{rkd_value[7:0]}};
      end else if (st_h) begin
        data_sram_we    = alu_result[1] ? 4'b1100 : 4'b0011;
        data_sram_wdata = {2{rkd_value[15:0]}};
      end else if (st_w) begin
        data_sram_we    = 4'b1111;
      end
    end
  end

  logic [EX_TO_MEM_WIDTH-1:0] out_bundle;
  assign out_bundle = {rf_we, rf_waddr, pc, alu_result,
                       ld_b, ld_bu, ld_h, ld_hu, ld_w,
                       |mul_op_r, div_any, div_result};
  assign ex_to_mem_wire = out_bundle;

  assign ex_rf_zip = {rf_we & ex_valid, res_from_mem, rf_waddr, alu_result};

endmodule
